// File: rtl/plic_target_arbiter.sv
// rtl/plic_target_arbiter.sv - per-target PLIC arbiter with claim/complete handling
// Pending latch, max-priority selection above threshold, claim FSM and completion pulses.
module plic_target_arbiter #(
  parameter int Number_of_Sources = 5,
  parameter int Interrupt_Width   = 3,
  parameter int ID_W              = $clog2(Number_of_Sources + 1)
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [Number_of_Sources-1:0]                 interrupt_request,
  input  logic [Number_of_Sources*Interrupt_Width-1:0] priority_flat,
  input  logic [Interrupt_Width-1:0]                   threshold,
  input  logic                                         claim_req,
  output logic                                         claim_ready,
  output logic                                         claim_valid,
  output logic [ID_W-1:0]                              claim_id,
  input  logic                                         complete_valid,
  input  logic [ID_W-1:0]                              complete_id,
  output logic [Number_of_Sources-1:0]                 interrupt_complete,
  output logic                                         eip,
  output logic [Number_of_Sources-1:0]                 pending,
  output logic [Number_of_Sources-1:0]                 in_service
);

  localparam int N = Number_of_Sources;
  localparam int W = Interrupt_Width;

  typedef enum logic [1:0] {C_IDLE, C_RESP, C_SETTLE} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    req_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    in_service_q, in_service_d;
  logic [N-1:0]    interrupt_complete_q;
  logic [N-1:0]    claim_mask, cmp_mask;
  logic [ID_W-1:0] best_id_q;
  logic [ID_W-1:0] claim_id_q;
  logic            claim_valid_q;
  logic            eip_q;
  logic            claim_accept;
  logic [ID_W-1:0] arb_id;
  logic [W-1:0]    arb_prio;

  // Strict '>' keeps the lowest ID on priority ties.
  always_comb begin
    arb_id   = '0;
    arb_prio = '0;
    for (int k = 0; k < N; k++) begin
      if (pending_q[k] && !in_service_q[k] &&
          (priority_flat[k*W +: W] > threshold) &&
          (priority_flat[k*W +: W] > arb_prio)) begin
        arb_id   = ID_W'(k + 1);
        arb_prio = priority_flat[k*W +: W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    claim_accept = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (claim_req) begin
          state_d      = C_RESP;
          claim_accept = 1'b1;
        end
      end
      C_RESP:   state_d = C_SETTLE;
      C_SETTLE: state_d = C_IDLE;
      default:  state_d = C_IDLE;
    endcase
  end

  // Completion checks the pre-update in_service, so a same-cycle claim cannot be completed.
  always_comb begin
    claim_mask = '0;
    cmp_mask   = '0;
    for (int k = 0; k < N; k++) begin
      if (claim_accept && (best_id_q == ID_W'(k + 1))) begin
        claim_mask[k] = 1'b1;
      end
      if (complete_valid && (complete_id == ID_W'(k + 1)) && in_service_q[k]) begin
        cmp_mask[k] = 1'b1;
      end
    end
  end

  assign pending_d    = (pending_q & ~claim_mask) | (interrupt_request & ~req_q);
  assign in_service_d = (in_service_q & ~cmp_mask) | claim_mask;

  always_ff @(posedge clk) begin
    req_q <= interrupt_request;
    if (reset) begin
      state_q              <= C_IDLE;
      pending_q            <= '0;
      in_service_q         <= '0;
      best_id_q            <= '0;
      eip_q                <= 1'b0;
      claim_valid_q        <= 1'b0;
      claim_id_q           <= '0;
      interrupt_complete_q <= '0;
    end else begin
      state_q              <= state_d;
      pending_q            <= pending_d;
      in_service_q         <= in_service_d;
      best_id_q            <= arb_id;
      eip_q                <= (arb_id != '0) && (state_d == C_IDLE);
      claim_valid_q        <= claim_accept;
      interrupt_complete_q <= cmp_mask;
      if (claim_accept) begin
        claim_id_q <= best_id_q;
      end
    end
  end

  assign claim_ready        = (state_q == C_IDLE);
  assign claim_valid        = claim_valid_q;
  assign claim_id           = claim_id_q;
  assign interrupt_complete = interrupt_complete_q;
  assign eip                = eip_q;
  assign pending            = pending_q;
  assign in_service         = in_service_q;

endmodule

// File: tb/tb_plic_target_arbiter.sv
// tb/tb_plic_target_arbiter.sv - randomized bench for plic_target_arbiter
// Reference model picks the winner by scanning priority levels from the top down.
module tb_plic_target_arbiter;

  localparam int N   = 5;
  localparam int W   = 3;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   interrupt_request;
  logic [N*W-1:0] priority_flat;
  logic [W-1:0]   threshold;
  logic           claim_req;
  logic           claim_ready;
  logic           claim_valid;
  logic [IDW-1:0] claim_id;
  logic           complete_valid;
  logic [IDW-1:0] complete_id;
  logic [N-1:0]   interrupt_complete;
  logic           eip;
  logic [N-1:0]   pending;
  logic [N-1:0]   in_service;

  always #5 clk = ~clk;

  plic_target_arbiter #(
    .Number_of_Sources(N),
    .Interrupt_Width(W),
    .ID_W(IDW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .interrupt_request(interrupt_request),
    .priority_flat(priority_flat),
    .threshold(threshold),
    .claim_req(claim_req),
    .claim_ready(claim_ready),
    .claim_valid(claim_valid),
    .claim_id(claim_id),
    .complete_valid(complete_valid),
    .complete_id(complete_id),
    .interrupt_complete(interrupt_complete),
    .eip(eip),
    .pending(pending),
    .in_service(in_service)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0] m_pend, m_insvc, m_prev, m_icomp;
  int           m_best, m_busy, m_cid;
  bit           m_eip, m_cv;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] p, input logic [N-1:0] s,
                              input logic [N*W-1:0] pr, input int th);
    for (int lvl = (1 << W) - 1; lvl > th; lvl--) begin
      for (int k = 0; k < N; k++) begin
        if (p[k] && !s[k] && (int'(pr[k*W +: W]) == lvl)) return k + 1;
      end
    end
    return 0;
  endfunction

  task automatic model_step();
    int  nb;
    int  cidx;
    bit  accept;
    if (reset) begin
      m_pend = '0; m_insvc = '0; m_icomp = '0;
      m_best = 0; m_busy = 0; m_cid = 0; m_eip = 0; m_cv = 0;
    end else begin
      nb     = pick(m_pend, m_insvc, priority_flat, int'(threshold));
      accept = claim_req && (m_busy == 0);
      cidx   = -1;
      if (complete_valid && int'(complete_id) >= 1 && int'(complete_id) <= N &&
          m_insvc[int'(complete_id) - 1]) begin
        cidx = int'(complete_id) - 1;
      end
      m_busy  = accept ? 2 : ((m_busy > 0) ? m_busy - 1 : 0);
      m_icomp = '0;
      if (cidx >= 0) begin
        m_icomp[cidx] = 1'b1;
        m_insvc[cidx] = 1'b0;
      end
      m_cv = accept;
      if (accept) begin
        m_cid = m_best;
        if (m_best != 0) begin
          m_pend[m_best - 1]  = 1'b0;
          m_insvc[m_best - 1] = 1'b1;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (interrupt_request[k] && !m_prev[k]) m_pend[k] = 1'b1;
      end
      m_best = nb;
      m_eip  = (nb != 0) && (m_busy == 0);
    end
    m_prev = interrupt_request;
  endtask

  task automatic compare_all();
    check_eq("claim_ready", 32'(claim_ready), 32'(m_busy == 0));
    check_eq("claim_valid", 32'(claim_valid), 32'(m_cv));
    check_eq("claim_id", 32'(claim_id), 32'(m_cid));
    check_eq("eip", 32'(eip), 32'(m_eip));
    check_eq("pending", 32'(pending), 32'(m_pend));
    check_eq("in_service", 32'(in_service), 32'(m_insvc));
    check_eq("interrupt_complete", 32'(interrupt_complete), 32'(m_icomp));
  endtask

  task automatic new_priorities();
    for (int k = 0; k < N; k++) priority_flat[k*W +: W] = W'($urandom_range(0, 4));
  endtask

  initial begin
    m_prev = '0;
    reset = 1'b1;
    interrupt_request = N'($urandom);
    new_priorities();
    threshold = '0;
    claim_req = 1'b0;
    complete_valid = 1'b0;
    complete_id = '0;
    repeat (3) begin
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
    compare_all();
    reset = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 19) == 0) new_priorities();
      if ($urandom_range(0, 29) == 0) threshold = W'($urandom_range(0, 3));
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) interrupt_request[k] = ~interrupt_request[k];
      end
      claim_req      = ($urandom_range(0, 3) == 0);
      complete_valid = ($urandom_range(0, 2) == 0);
      complete_id    = IDW'($urandom_range(0, 7));
      if (m_insvc != '0 && $urandom_range(0, 1) == 0) begin
        int start;
        start = $urandom_range(0, N - 1);
        for (int j = 0; j < N; j++) begin
          if (m_insvc[(start + j) % N]) complete_id = IDW'(((start + j) % N) + 1);
        end
      end
      reset = ((cyc % 700) == 350) || ((cyc % 700) == 351);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
